// File: rtl/hazard_ctrl_pkg.sv
// Shared types for hazard_ctrl: bus payload structs, bus FSM state and stage control bundle.
package hazard_ctrl_pkg;

  localparam int unsigned BUS_AW = 32;
  localparam int unsigned BUS_DW = 32;
  localparam int unsigned BUS_SW = BUS_DW / 8;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_WAIT = 1'b1
  } bus_state_e;

  typedef struct packed {
    logic              valid;
    logic [BUS_AW-1:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic              addr_ok;
    logic              data_ok;
    logic [BUS_DW-1:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic              valid;
    logic [BUS_AW-1:0] addr;
    logic [BUS_SW-1:0] strobe;
    logic [BUS_DW-1:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic              addr_ok;
    logic              data_ok;
    logic [BUS_DW-1:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic stall_w;
    logic flush_e;
  } hazard_ctl_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Fetch/data bus bundle seen by the hazard controller; master = pipeline/bus side.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  logic       imask;
  logic       dmask;

  modport master (output ireq, iresp, dreq, dresp, input imask, dmask);
  modport slave  (input ireq, iresp, dreq, dresp, output imask, dmask);

endinterface

// File: rtl/hazard_ctrl_bus_wait_fsm.sv
// Per-bus handshake tracker: remembers an accepted request until its data returns.
module bus_wait_fsm
  import hazard_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic valid,
  input  logic addr_ok,
  input  logic data_ok,
  input  logic store,
  output logic mask,
  output logic wait_c
);

  bus_state_e state;

  // Stores finish at addr_ok, so only loads/fetches ever park in WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BUS_IDLE;
    end else begin
      case (state)
        BUS_IDLE: if (valid && addr_ok && !data_ok && !store) state <= BUS_WAIT;
        BUS_WAIT: if (data_ok) state <= BUS_IDLE;
        default:  state <= BUS_IDLE;
      endcase
    end
  end

  assign mask = (state == BUS_WAIT);

  always_comb begin
    wait_c = 1'b0;
    if (store) wait_c = !addr_ok;
    else       wait_c = (valid || (state == BUS_WAIT)) && !data_ok;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, per-stage stall/flush, bus wait and mult/div busy.
// Optional mult/div latency tracking is enabled with `define HAZARD_MULDIV_EN.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32
) (
  input  logic              clk,
  input  logic              reset,
  hazard_ctrl_if.slave      bus,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic              brD,
  input  logic              wrE,
  input  logic              wrM,
  input  logic              wrW,
  input  logic [REG_AW-1:0] wdstE,
  input  logic [REG_AW-1:0] wdstM,
  input  logic [REG_AW-1:0] wdstW,
  input  logic              loadE,
  input  logic              loadM,
  input  logic [DATA_W-1:0] vM,
  input  logic [DATA_W-1:0] vW,
  input  logic [DATA_W-1:0] vsD,
  input  logic [DATA_W-1:0] vtD,
  input  logic [DATA_W-1:0] vsE,
  input  logic [DATA_W-1:0] vtE,
  output logic [DATA_W-1:0] vsHD,
  output logic [DATA_W-1:0] vtHD,
  output logic [DATA_W-1:0] vsHE,
  output logic [DATA_W-1:0] vtHE,
  input  logic              mdStartE,
  input  logic              mdDivE,
  input  logic              mdD,
  input  logic              hiloRdD,
  output logic              mdBusy,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              stallW,
  output logic              flushE
);

  function automatic logic hit(input logic wr, input logic [REG_AW-1:0] dst,
                               input logic [REG_AW-1:0] src);
    return wr && (dst != '0) && (dst == src);
  endfunction

  logic        fwd_m;
  logic        iwait_c, dwait_c, dstore_c, freeze_c;
  logic        hz_c, hz_md_c;
  hazard_ctl_t ctl;

  assign fwd_m = wrM && !loadM;

  // M result beats W writeback; D only needs M since the regfile is write-first.
  always_comb begin
    vsHE = vsE;
    vtHE = vtE;
    vsHD = vsD;
    vtHD = vtD;
    if (hit(fwd_m, wdstM, rsE))      vsHE = vM;
    else if (hit(wrW, wdstW, rsE))   vsHE = vW;
    if (hit(fwd_m, wdstM, rtE))      vtHE = vM;
    else if (hit(wrW, wdstW, rtE))   vtHE = vW;
    if (hit(fwd_m, wdstM, rsD))      vsHD = vM;
    if (hit(fwd_m, wdstM, rtD))      vtHD = vM;
  end

  assign dstore_c = bus.dreq.valid && (bus.dreq.strobe != '0);

  bus_wait_fsm u_ibus_fsm (
    .clk     (clk),
    .reset   (reset),
    .valid   (bus.ireq.valid),
    .addr_ok (bus.iresp.addr_ok),
    .data_ok (bus.iresp.data_ok),
    .store   (1'b0),
    .mask    (bus.imask),
    .wait_c  (iwait_c)
  );

  bus_wait_fsm u_dbus_fsm (
    .clk     (clk),
    .reset   (reset),
    .valid   (bus.dreq.valid),
    .addr_ok (bus.dresp.addr_ok),
    .data_ok (bus.dresp.data_ok),
    .store   (dstore_c),
    .mask    (bus.dmask),
    .wait_c  (dwait_c)
  );

  assign freeze_c = iwait_c || dwait_c;

`ifdef HAZARD_MULDIV_EN
  localparam int unsigned MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  logic [CNT_W-1:0] cnt;

  // Counts remaining busy cycles; keeps running through a bus freeze.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (mdStartE && !freeze_c) begin
      cnt <= mdDivE ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign mdBusy  = (cnt != '0);
  assign hz_md_c = (mdD || hiloRdD) && (mdBusy || mdStartE);
`else
  localparam int unsigned unused_lat = MUL_LAT + DIV_LAT;
  logic unused_md;

  assign unused_md = ^{mdStartE, mdDivE, mdD, hiloRdD, unused_lat[0]};
  assign mdBusy    = 1'b0;
  assign hz_md_c   = 1'b0;
`endif

  assign hz_c = hit(loadE, wdstE, rsD) || hit(loadE, wdstE, rtD) ||
                (brD && (hit(wrE, wdstE, rsD) || hit(wrE, wdstE, rtD) ||
                         hit(loadM, wdstM, rsD) || hit(loadM, wdstM, rtD))) ||
                hz_md_c;

  // A bus freeze holds every stage and must not inject a bubble.
  always_comb begin
    ctl = '0;
    if (freeze_c) begin
      ctl.stall_f = 1'b1;
      ctl.stall_d = 1'b1;
      ctl.stall_e = 1'b1;
      ctl.stall_m = 1'b1;
      ctl.stall_w = 1'b1;
    end else if (hz_c) begin
      ctl.stall_f = 1'b1;
      ctl.stall_d = 1'b1;
      ctl.flush_e = 1'b1;
    end
  end

  assign stallF = ctl.stall_f;
  assign stallD = ctl.stall_d;
  assign stallE = ctl.stall_e;
  assign stallM = ctl.stall_m;
  assign stallW = ctl.stall_w;
  assign flushE = ctl.flush_e;

  logic unused_bus;
  assign unused_bus = ^{bus.ireq.addr, bus.iresp.data, bus.dreq.addr,
                        bus.dreq.data, bus.dresp.data};

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the five-stage MIPS core, sitting beside the decode/execute datapath and the ibus/dbus ports. It adds two things to plain operand forwarding and load/branch stall detection. First, it tracks outstanding bus transactions with handshake FSMs, so an accepted request is never re-issued. Second, it tracks a multi-cycle mult/div unit with a latency counter. It emits per-stage stall/flush controls instead of one global stall.

## Interface
Parameters:
- DATA_W, 32, datapath width
- REG_AW, 5, register address width; register 0 is hardwired zero
- MUL_LAT, 4, mult latency in cycles (≥1)
- DIV_LAT, 32, div latency in cycles (≥1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ireq / iresp  in  ibus_req_t / ibus_resp_t  fetch bus request and response
- dreq / dresp  in  dbus_req_t / dbus_resp_t  data bus request and response
- imask / dmask  out  1  when high, the fetch/mem stage must drive req.valid low (request already accepted, awaiting data)
- rsD, rtD, rsE, rtE  in  REG_AW  source registers in D and E
- brD  in  1  the D instruction consumes operands in D (beq/bne/jr)
- wrE, wrM, wrW  in  1  stage writes the register file
- wdstE, wdstM, wdstW  in  REG_AW  destination register per stage
- loadE, loadM  in  1  stage holds a load
- vM, vW  in  DATA_W  M ALU result; W writeback value
- vsD, vtD, vsE, vtE  in  DATA_W  unforwarded operands
- vsHD, vtHD, vsHE, vtHE  out  DATA_W  forwarded operands
- mdStartE  in  1  mult/div issuing in E
- mdDivE  in  1  qualifies mdStartE as div
- mdD, hiloRdD  in  1  D holds mult/div, or holds mfhi/mflo
- mdBusy  out  1  mult/div unit busy
- stallF, stallD, stallE, stallM, stallW  out  1  hold the stage register
- flushE  out  1  load a bubble into E

## Operation
- Forwarding in E, per operand: match with M (wrM & !loadM & wdst≠0) wins over a W match, which wins over the raw value. Forwarding in D (brD): M only (non-load), else raw; W is covered by the register file's write-first behaviour.
- Data hazard (`hz`):
  - loadE & wdstE ∈ {rsD, rtD}
  - brD & wrE & wdstE ∈ {rsD, rtD}
  - brD & loadM & wdstM ∈ {rsD, rtD}
  - (mdD | hiloRdD) & (mdBusy | mdStartE)
  - A destination of 0 never matches.
- Bus FSMs (ibus, dbus separately): IDLE, WAIT.
  - IDLE→WAIT on valid & addr_ok & !data_ok.
  - WAIT→IDLE on data_ok.
  - mask = (state == WAIT).
  - Stores complete at addr_ok; data_ok is ignored for them (strobe ≠ 0).
- Bus wait:
  - iwait = (ireq.valid & !iresp.data_ok) | (IWAIT & !iresp.data_ok)
  - dwait = load: (valid | WAIT) & !data_ok; store: valid & !addr_ok
- freeze = iwait | dwait. When high: stallF..stallW all high and flushE low.
- Otherwise, on hz: stallF = stallD = 1 and flushE = 1.
- Mult/div counter (`cnt`):
  - On mdStartE & !stallE: cnt ← (mdDivE ? DIV_LAT : MUL_LAT) − 1.
  - Else, when cnt ≠ 0: cnt decrements every cycle, freeze included.
  - mdBusy = (cnt ≠ 0).

## Timing
- Reset: both FSMs IDLE, cnt = 0; imask = dmask = mdBusy = 0. Stalls/flush reflect inputs only.
- Stalls, flush and forwarding are combinational, same cycle. Mask changes one cycle after the handshake.
- Same-cycle addr_ok and data_ok: transaction complete, FSM stays IDLE, no mask.
- Reset mid-transaction: FSM returns to IDLE next edge; the stale data_ok that follows is ignored.
- hz and freeze together: freeze wins; hz re-evaluates after release.
- mdStartE while busy cannot occur (hz blocks it in D); if forced, cnt reloads.

## Configuration
- HAZARD_MULDIV_EN defined: cnt, mdBusy and the mdD/hiloRdD stall are present.
- Undefined: mdBusy = 0, no counter, mult/div treated as single-cycle, MUL_LAT/DIV_LAT unused.

## Structure
- In the shared package: bus FSM state enum (BUS_IDLE, BUS_WAIT), and a hazard control struct {stallF..stallW, flushE}.
- Sub-module bus_wait_fsm, instantiated twice (ibus, dbus), with a store-completes-on-addr_ok input.

## Test plan
- E forwarding: wrM, wdstM=3, vM=0x11; wrW, wdstW=3, vW=0x22; rsE=3 → vsHE=0x11; drop wrM → 0x22; rsE=0 → raw vsE.
- Load-use: loadE, wdstE=5, rtD=5 → stallF=stallD=flushE=1 for one cycle; next cycle (loadM) clear unless brD.
- Dbus load: addr_ok at cycle 1, data_ok at cycle 4 → dmask=1 cycles 2–4; freeze 1–3 (clears at data_ok); FSM IDLE at cycle 5.
- Store: valid, strobe=0xF, addr_ok at cycle 2 → freeze cycles 0–1 only; dmask never high.
- Div: mdStartE, mdDivE, DIV_LAT=32 → mdBusy for 31 cycles; hiloRdD stalls D through the last busy cycle, released the cycle mdBusy=0.
- Reset with dbus in WAIT → dmask=0, cnt=0 next cycle; a late data_ok causes no state change.
